// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART blocks: parity modes, receiver
// state encoding, baud divisor computation and parameter legality checks.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  // Rounded clocks per oversample tick; 0 flags an unusable configuration.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud,
                                           input int unsigned os);
    longint unsigned den;
    longint unsigned num;
    den = longint'(baud) * longint'(os);
    if (den == 0) return 0;
    num = longint'(clk_hz) + den / 2;
    return int'(num / den);
  endfunction

  function automatic bit data_bits_ok(input int unsigned n);
    return (n >= 5) && (n <= 9);
  endfunction

  function automatic bit stop_bits_ok(input int unsigned n);
    return (n == 1) || (n == 2);
  endfunction

  function automatic bit oversample_ok(input int unsigned n);
    return (n >= 8) && ((n % 2) == 0);
  endfunction

  function automatic bit parity_ok(input int unsigned p);
    return p <= PAR_EVEN;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divide-by-Div counter producing a one-clock tick; a synchronous
// clear realigns it so the next tick lands exactly Div clocks later.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned Div = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i || (cnt_q == CntMax)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == CntMax) && !clr_i;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF synchroniser, oversampled 3-sample majority
// vote, false-start rejection, parity/framing/overrun flags, ready/valid output.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int unsigned Div   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned Mid   = OVERSAMPLE / 2;
  localparam int unsigned ScntW = $clog2(OVERSAMPLE);
  localparam int unsigned BidxW = $clog2(DATA_BITS);

  localparam logic [ScntW-1:0] ScntMidM1 = ScntW'(Mid - 1);
  localparam logic [ScntW-1:0] ScntMid   = ScntW'(Mid);
  localparam logic [ScntW-1:0] ScntMidP1 = ScntW'(Mid + 1);
  localparam logic [ScntW-1:0] ScntLast  = ScntW'(OVERSAMPLE - 1);
  localparam logic [BidxW-1:0] DataLast  = BidxW'(DATA_BITS - 1);
  localparam logic [BidxW-1:0] StopLast  = BidxW'(STOP_BITS - 1);

  if (Div < 1) begin : g_err_div
    $error("uart_rx_param: CLK_HZ/(BAUD*OVERSAMPLE) rounds below 1");
  end
  if (!data_bits_ok(DATA_BITS)) begin : g_err_data
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (!stop_bits_ok(STOP_BITS)) begin : g_err_stop
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if (!oversample_ok(OVERSAMPLE)) begin : g_err_os
    $error("uart_rx_param: OVERSAMPLE must be even and >= 8");
  end
  if (!parity_ok(PARITY)) begin : g_err_par
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end

  // [0],[1] synchroniser stages, [2] previous synchronised value for edge detect.
  logic [2:0] sync_q;
  logic       rxs;
  logic       fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], rxd_i};
    end
  end

  assign rxs  = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];

  rx_state_e            state_q;
  logic [ScntW-1:0]     scnt_q;
  logic [BidxW-1:0]     bidx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [1:0]           samp_q;
  logic                 perr_pend_q;
  logic                 ferr_pend_q;
  logic                 done_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 overrun_q;
  logic                 busy_q;

  logic start_det;
  logic tick;
  logic vote;
  logic is_vote;
  logic is_end;
  logic par_exp;

  assign start_det = (state_q == StIdle) && fall;

  uart_baud_tick #(
    .Div (Div)
  ) u_baud_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (start_det),
    .tick_o (tick)
  );

  always_comb begin
    vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
    is_vote = tick && (scnt_q == ScntMidP1);
    is_end  = tick && (scnt_q == ScntLast);
    par_exp = (PARITY == PAR_ODD) ? ~(^shift_q) : (^shift_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      scnt_q      <= '0;
      bidx_q      <= '0;
      shift_q     <= '0;
      samp_q      <= 2'b11;
      perr_pend_q <= 1'b0;
      ferr_pend_q <= 1'b0;
      done_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      done_q    <= 1'b0;

      // A completing frame may replace data being accepted in the same cycle.
      if (done_q) begin
        if (!rx_valid_q || rx_ready_i) begin
          rx_data_q  <= shift_q;
          perr_q     <= perr_pend_q;
          ferr_q     <= ferr_pend_q;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end

      if (tick) begin
        scnt_q <= (scnt_q == ScntLast) ? '0 : scnt_q + 1'b1;
        if (scnt_q == ScntMidM1) samp_q[0] <= rxs;
        if (scnt_q == ScntMid)   samp_q[1] <= rxs;
      end

      unique case (state_q)
        StIdle: begin
          if (fall) begin
            state_q     <= StStart;
            scnt_q      <= '0;
            bidx_q      <= '0;
            perr_pend_q <= 1'b0;
            ferr_pend_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        StStart: begin
          if (is_vote && vote) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (is_end) begin
            state_q <= StData;
            bidx_q  <= '0;
          end
        end
        StData: begin
          if (is_vote) shift_q <= {vote, shift_q[DATA_BITS-1:1]};
          if (is_end) begin
            if (bidx_q == DataLast) begin
              bidx_q  <= '0;
              state_q <= (PARITY != PAR_NONE) ? StParity : StStop;
            end else begin
              bidx_q <= bidx_q + 1'b1;
            end
          end
        end
        StParity: begin
          if (is_vote) perr_pend_q <= vote ^ par_exp;
          if (is_end) begin
            state_q <= StStop;
            bidx_q  <= '0;
          end
        end
        StStop: begin
          // Finish on the last stop vote so skewed back-to-back frames still align.
          if (is_vote) begin
            if (!vote) ferr_pend_q <= 1'b1;
            if (bidx_q == StopLast) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else if (is_end) begin
            bidx_q <= bidx_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = busy_q;

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8-bit/50 MHz receiver. It supports configurable clock/baud, oversampling ratio, 5–9 data bits, optional parity and 1/2 stop bits. It uses 3-sample majority voting, false-start rejection, framing/parity/overrun flags and a ready/valid output. It sits between the pad-side rxd pin and any byte consumer (FIFO, command parser).

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, line bit rate
OVERSAMPLE, 16, sample ticks per bit; even, >=8
DATA_BITS, 8, payload bits per frame, legal 5..9
PARITY, 0, 0 none / 1 odd / 2 even
STOP_BITS, 1, 1 or 2
(derived) DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)), must be >=1; elaboration error otherwise

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
rxd  in  1  asynchronous serial line, idle high
rx_data  out  DATA_BITS  received payload, LSB = first bit on line
rx_valid  out  1  rx_data/flags valid; held until accepted
rx_ready  in  1  consumer accepts when rx_valid && rx_ready
parity_err  out  1  parity mismatch for current rx_data; 0 when PARITY=0
frame_err  out  1  any stop bit sampled 0 for current rx_data
overrun  out  1  one-clk pulse: completed frame dropped because rx_valid still pending
busy  out  1  high from start detection until return to IDLE

Behaviour:
- Reset: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, synchroniser flops=1 (no false start after reset).
- rxd passes through a 2-FF synchroniser; start detect = synchronised falling edge (prev 1, now 0).
- Tick generator: counter 0..DIV-1, free-running; cleared on start detect so the first tick falls DIV clks later. One-clk tick at DIV-1.
- Sample counter scnt 0..OVERSAMPLE-1 advances per tick. The bit value is the majority of samples at scnt = M-1, M, M+1, where M = OVERSAMPLE/2. The vote is resolved on the tick at M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on start detect go to START, scnt=0, busy=1.
- START: if the vote is 1 (glitch), go to IDLE with busy=0 and no outputs touched. Else at scnt=OVERSAMPLE-1 go to DATA with bit index 0.
- DATA: shift the voted bit in LSB-first. After bit DATA_BITS-1 ends, go to PARITY if PARITY!=0, else STOP.
- PARITY: compare the voted bit with the computed parity. Odd: XOR(data)^1; even: XOR(data).
- STOP: vote each stop bit; any 0 sets the pending frame error. On the vote of the last stop bit, the frame completes and the FSM goes to IDLE immediately, without waiting for the bit end. This tolerates back-to-back frames with baud skew.
- Completion, in the clk after the last stop vote:
  - If rx_valid=0, or rx_ready=1 in that same cycle: load rx_data, parity_err, frame_err and set rx_valid=1.
  - Else: assert overrun for 1 clk; the new frame is discarded and the old data and flags are held.
- rx_valid clears the clk after rx_valid && rx_ready, unless a completion loads in that same cycle (then it stays 1 with the new data).
- Break (line low indefinitely): delivers one frame with data=0 and frame_err=1. No further frame until the line returns high and falls again.
- Reset mid-frame: immediate return to reset state; the partial frame is lost.
- Latency: rx_valid rises (M+1)*DIV + 3 clks (±1) after the start of the last stop bit on rxd.

Decomposition:
- Shared package/include uart_pkg:
  - parity encodings PAR_NONE/PAR_ODD/PAR_EVEN
  - FSM state encoding
  - DIV computation function
  - legality checks for DATA_BITS/STOP_BITS/OVERSAMPLE
- One natural sub-module: uart_baud_tick (DIV counter with sync clear, tick output), reusable by the future parametrised transmitter.

Test Plan:
- DIV=1, OVERSAMPLE=16, 8N1; send 0xA5 with rx_ready=1 -> rx_data=0xA5, rx_valid for exactly 1 clk, parity_err=0, frame_err=0, busy low after completion.
- PARITY=2, DATA_BITS=7; send 0x3C with correct parity, then with inverted parity -> first frame parity_err=0, second rx_data=0x3C with parity_err=1.
- STOP_BITS=2; second stop bit driven 0 for 0x55 -> frame_err=1, rx_data=0x55. Hold line low 30 bit times -> exactly one frame (0x00, frame_err=1), no more until line high and falling again.
- Low glitch of 4 clks on idle line -> no rx_valid, busy returns 0 by scnt M+1, next real frame 0x81 received correctly.
- rx_ready=0; send 0x11 then 0x22 back-to-back -> rx_data stays 0x11, overrun pulses 1 clk at 0x22 completion. Raise rx_ready -> rx_valid drops next clk.
- Assert rst_n low during data bit 3 of a frame -> all outputs 0, no rx_valid. After release, send 0xC3 -> rx_data=0xC3, no errors.
